vfb_burst_reader: RTL and testbench
===================================

// Module: vfb_burst_reader
// PURPOSE
//  Avalon-MM burst-read host that fetches a 32-bit/pixel frame buffer from DRAM.
//  Emits the frame as an Avalon-ST video stream with SOP/EOP framing.
//  Counterpart of the stream-to-MM burst writer: same bus, read direction.
//  Sits between the f2h SDRAM port and the video pipeline; a FIFO decouples
//  DRAM latency from stream backpressure.
// PARAMETERS
//  HDISP       800   pixels per line
//  VDISP       480   lines per frame
//  BURST       16    words per read burst (power of 2, <= FIFO_DEPTH/2)
//  FIFO_DEPTH  256   pixel FIFO entries (power of 2)
//  BC_W        5     burstcount width (must hold BURST)
// PORTS
//  clk            in   1     system clock
//  sys_rst        in   1     asynchronous reset, active high
//  enable         in   1     run frames continuously while high
//  base_addr      in   32    byte address of frame; bits [1:0] ignored
//  address        out  32    Avalon-MM byte address
//  burstcount     out  BC_W  Avalon-MM burst length
//  read           out  1     Avalon-MM read request
//  waitrequest    in   1     Avalon-MM stall
//  readdata       in   32    Avalon-MM read data
//  readdatavalid  in   1     Avalon-MM read data strobe
//  st_data        out  32    stream pixel
//  st_valid       out  1     stream valid
//  st_ready       in   1     stream ready
//  st_sop         out  1     first pixel of frame
//  st_eop         out  1     last pixel of frame
//  underflow_cnt  out  32    starvation counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset: read=0, address=0, burstcount=0, st_valid=0, st_sop=0, st_eop=0,
//  underflow_cnt=0, FIFO empty, FSM=IDLE, all counters 0.
//  Frame size N = HDISP*VDISP words; address step = BURST*4 bytes.
//  FSM request side:
//  - IDLE: if enable, latch base_addr into frame_base, words_left=N -> CHECK.
//  - CHECK: free = FIFO_DEPTH - fifo_count - outstanding.
//    If free >= len, where len = min(BURST, words_left) -> REQ.
//  - REQ: read=1, address/burstcount held stable until waitrequest=0.
//    On acceptance: outstanding += len; words_left -= len; address += len*4.
//    Next state: words_left==0 -> DRAIN, else CHECK.
//    Back-to-back bursts may be issued without a gap.
//  - DRAIN: wait until the stream pixel count reaches N, then return to IDLE.
//    A new frame starts in the same cycle if enable is high.
//  Response side: each readdatavalid pushes readdata into the FIFO and decrements
//  outstanding. The credit check guarantees this never overflows; an overflow is
//  an assertion failure.
//  Stream side: st_valid = FIFO not empty, registered output (show-ahead).
//  A transfer is valid&&ready. st_valid never depends combinationally on st_ready.
//  Data is held stable while valid && !ready.
//  st_sop=1 on pixel index 0; st_eop=1 on pixel index N-1.
//  The pixel index wraps to 0 after EOP.
//  enable low mid-frame: the current frame completes fully, then IDLE.
//  base_addr change mid-frame: takes effect at the next frame (latched in IDLE).
//  Final burst is shorter if N % BURST != 0.
//  Address and burstcount change only when read=0 or a burst is accepted.
//  Simultaneous push and pop: the FIFO count is unchanged.
//  A pop is allowed in the same cycle a push makes the FIFO non-empty only
//  on the next cycle (1-cycle FIFO latency).
//  sys_rst mid-frame: immediate abort, all state cleared.
//  Readdatavalid arriving after reset for pre-reset bursts is not expected;
//  the fabric is reset together with this block.
// CONFIGURATION
//  VFB_UNDERFLOW_CNT_EN defined:
//  - underflow_cnt increments each cycle with st_ready=1 and FIFO empty while a
//    frame is in progress (after first SOP, before EOP).
//  - The counter saturates at 2^32-1 and clears only on reset.
//  Not defined: underflow_cnt tied to 0; no counter logic synthesised.
// TESTING
//  1. HDISP=8,VDISP=2,BURST=4, st_ready=1, zero-latency memory: 4 bursts at
//     base,+16,+32,+48; 16 pixels out, SOP on pixel 0, EOP on pixel 15.
//  2. waitrequest=1 for 10 cycles on burst 2: address/burstcount/read held
//     stable; no second request issued early.
//  3. st_ready=0 throughout, FIFO_DEPTH=16, BURST=4: exactly 4 bursts issued,
//     then read stays 0; st_data frozen at pixel 0.
//  4. N=10, BURST=4: bursts of 4,4,2; EOP on pixel 9; enable held high ->
//     next SOP follows with base_addr re-latched.
//  5. Assert sys_rst mid-burst: outputs at reset values within the same cycle;
//     after release with enable=1, the frame restarts at base_addr with SOP.
//  6. VFB_UNDERFLOW_CNT_EN: memory latency 20 cycles, st_ready=1 ->
//     underflow_cnt equals the counted empty cycles; 0 when the macro is off.

Source files
------------

// File: rtl/vfb_burst_reader.sv
// vfb_burst_reader
//   Avalon-MM burst-read host that fetches a 32-bit/pixel frame buffer from
//   DRAM and replays it as an Avalon-ST video stream with SOP/EOP framing.
//   A credit-checked pixel FIFO decouples DRAM latency from stream backpressure.
//
// Ports
//   clk, sys_rst        clock, asynchronous active-high reset
//   enable              run frames continuously while high
//   base_addr           frame byte address (bits [1:0] ignored), latched per frame
//   address/burstcount/read, waitrequest, readdata/readdatavalid
//                       Avalon-MM burst-read host
//   st_data/st_valid/st_ready/st_sop/st_eop
//                       Avalon-ST video source
//   underflow_cnt       stream starvation counter
//
// Configuration
//   VFB_UNDERFLOW_CNT_EN  when defined, underflow_cnt counts cycles with
//                         st_ready=1 and an empty FIFO inside a frame
//                         (saturating); otherwise it is tied to zero.
module vfb_burst_reader #(
  parameter int unsigned HDISP      = 800,
  parameter int unsigned VDISP      = 480,
  parameter int unsigned BURST      = 16,
  parameter int unsigned FIFO_DEPTH = 256,
  parameter int unsigned BC_W       = 5
) (
  input  logic            clk,
  input  logic            sys_rst,
  input  logic            enable,
  input  logic [31:0]     base_addr,
  output logic [31:0]     address,
  output logic [BC_W-1:0] burstcount,
  output logic            read,
  input  logic            waitrequest,
  input  logic [31:0]     readdata,
  input  logic            readdatavalid,
  output logic [31:0]     st_data,
  output logic            st_valid,
  input  logic            st_ready,
  output logic            st_sop,
  output logic            st_eop,
  output logic [31:0]     underflow_cnt
);

  localparam int unsigned N  = HDISP * VDISP;
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {IDLE, CHECK, REQ, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [31:0]     words_left;
  logic [31:0]     len;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   mcount;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [31:0]     mem [FIFO_DEPTH];
  logic [31:0]     pix_idx;
  logic            credit_ok, accept, last_burst, frame_start;
  logic            push, pop, eop_pop;
  logic            out_load, mem_pop, mem_push, bypass, fifo_empty;
  logic            unused_ok;

  assign unused_ok = &{1'b0, base_addr[1:0]};

  assign len        = (words_left < 32'(BURST)) ? words_left : 32'(BURST);
  // Credits cover words already buffered plus words still in flight.
  assign credit_ok  = (32'(mcount) + 32'(st_valid) + 32'(outstanding) + len) <= 32'(FIFO_DEPTH);
  assign accept     = read && !waitrequest;
  assign last_burst = (words_left == 32'(burstcount));

  assign push       = readdatavalid;
  assign pop        = st_valid && st_ready;
  assign eop_pop    = pop && (pix_idx == 32'(N - 1));
  assign fifo_empty = !st_valid && (mcount == '0);

  // The output register is the FIFO head. When it is free and the memory is
  // empty, incoming data bypasses straight into it for one-cycle latency.
  assign out_load = !st_valid || pop;
  assign mem_pop  = out_load && (mcount != '0);
  assign bypass   = out_load && (mcount == '0) && push;
  assign mem_push = push && !bypass;

  assign st_sop = st_valid && (pix_idx == 32'd0);
  assign st_eop = st_valid && (pix_idx == 32'(N - 1));

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    read        = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          frame_start = 1'b1;
          state_nxt   = CHECK;
        end
      end
      CHECK: begin
        if (credit_ok) state_nxt = REQ;
      end
      REQ: begin
        read = 1'b1;
        if (accept) state_nxt = last_burst ? DRAIN : CHECK;
      end
      DRAIN: begin
        if (eop_pop) begin
          frame_start = enable;
          state_nxt   = enable ? CHECK : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      address     <= '0;
      burstcount  <= '0;
      words_left  <= '0;
      outstanding <= '0;
    end else begin
      if (frame_start) begin
        address    <= {base_addr[31:2], 2'b00};
        words_left <= 32'(N);
      end else if (accept) begin
        address    <= address + (32'(burstcount) << 2);
        words_left <= words_left - 32'(burstcount);
      end
      if (state == CHECK && credit_ok) burstcount <= BC_W'(len);
      outstanding <= outstanding + (accept ? CW'(burstcount) : CW'(0))
                                 - (push ? CW'(1) : CW'(0));
    end
  end

  always_ff @(posedge clk) begin
    if (mem_push) mem[wr_ptr] <= readdata;
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mcount   <= '0;
      st_valid <= 1'b0;
      st_data  <= '0;
      pix_idx  <= '0;
    end else begin
      if (mem_push) wr_ptr <= wr_ptr + AW'(1);
      if (mem_pop)  rd_ptr <= rd_ptr + AW'(1);
      mcount <= mcount + (mem_push ? CW'(1) : CW'(0)) - (mem_pop ? CW'(1) : CW'(0));
      if (out_load) begin
        if (mem_pop) begin
          st_data  <= mem[rd_ptr];
          st_valid <= 1'b1;
        end else if (push) begin
          st_data  <= readdata;
          st_valid <= 1'b1;
        end else begin
          st_valid <= 1'b0;
        end
      end
      if (pop) pix_idx <= eop_pop ? 32'd0 : pix_idx + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!sys_rst) assert (!(mem_push && mcount == CW'(FIFO_DEPTH)));
  end

`ifdef VFB_UNDERFLOW_CNT_EN
  logic in_frame;

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      in_frame      <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      if (pop) in_frame <= !eop_pop;
      if (in_frame && st_ready && fifo_empty && underflow_cnt != '1)
        underflow_cnt <= underflow_cnt + 32'd1;
    end
  end
`else
  logic unused_uf;
  assign unused_uf     = &{1'b0, fifo_empty};
  assign underflow_cnt = '0;
`endif

endmodule

// File: tb/tb_vfb_burst_reader.sv
// Bench for vfb_burst_reader: small frame (5x2 pixels), BURST=4, FIFO_DEPTH=8.
// A transaction-level model (frame bases, word/credit counters, a response
// queue and a pixel index) predicts every request and every stream beat.
module tb_vfb_burst_reader;

  localparam int unsigned HDISP = 5;
  localparam int unsigned VDISP = 2;
  localparam int unsigned BURST = 4;
  localparam int          FDEPTH = 8;
  localparam int unsigned BC_W  = 5;
  localparam int          N     = HDISP * VDISP;

  logic            clk = 1'b0;
  logic            sys_rst, enable, waitrequest, readdatavalid, st_ready;
  logic [31:0]     base_addr, readdata;
  logic [31:0]     address, st_data, underflow_cnt;
  logic [BC_W-1:0] burstcount;
  logic            read, st_valid, st_sop, st_eop;

  always #5 clk = ~clk;

  vfb_burst_reader #(
    .HDISP(HDISP), .VDISP(VDISP), .BURST(BURST), .FIFO_DEPTH(FDEPTH), .BC_W(BC_W)
  ) dut (
    .clk(clk), .sys_rst(sys_rst), .enable(enable), .base_addr(base_addr),
    .address(address), .burstcount(burstcount), .read(read),
    .waitrequest(waitrequest), .readdata(readdata), .readdatavalid(readdatavalid),
    .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready),
    .st_sop(st_sop), .st_eop(st_eop), .underflow_cnt(underflow_cnt)
  );

  int checks = 0, errors = 0;

  // stimulus knobs
  int lat, wr_pct, rdy_pct, rdv_pct, stall_left, stall_used;
  bit force_ready0, stall_armed, rand_base;

  // model state
  int          cyc, fifo_m, outst_m, req_left, pidx, frames_open, eop_cnt, burst_in_frame;
  bit          req_active, start_ok, in_frame_m, prev_read, prev_wait;
  logic [31:0] req_addr, prev_addr, uf_m;
  logic [BC_W-1:0] prev_bc;
  logic [31:0] base_q[$];
  logic [31:0] rq_addr[$];
  int          rq_time[$];
  logic [31:0] acc_addr[$];
  int          acc_len[$];
  logic [31:0] pop_data[$];

  logic [31:0] exp_a [6] = '{32'h1000, 32'h1010, 32'h1020, 32'h2000, 32'h2010, 32'h2020};
  int          exp_l [6] = '{4, 4, 2, 4, 4, 2};

  function automatic logic [31:0] pix(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    bit newreq, acc, rdv_now, pop_now;
    int len;
    len = 0;
    @(negedge clk);
    // ---- compare DUT against model ----
    chk("st_valid", 32'(st_valid), 32'(fifo_m > 0));
    if (st_valid) begin
      if (base_q.size() == 0) chk("st_frame", 32'(st_valid), 32'd0);
      else begin
        chk("st_data", st_data, pix(base_q[0] + 32'(4 * pidx)));
        chk("st_sop", 32'(st_sop), 32'(pidx == 0));
        chk("st_eop", 32'(st_eop), 32'(pidx == N - 1));
      end
    end
    chk("underflow_cnt", underflow_cnt, uf_m);
    if (prev_read && prev_wait) begin
      chk("hold_read", 32'(read), 32'd1);
      chk("hold_address", address, prev_addr);
      chk("hold_burstcount", 32'(burstcount), 32'(prev_bc));
    end
    newreq = read && !(prev_read && prev_wait);
    if (newreq && !req_active) begin
      chk("frame_start_ok", 32'(frames_open == 0 && start_ok), 32'd1);
      req_active = 1; req_left = N; req_addr = base_addr & ~32'h3;
      base_q.push_back(req_addr); frames_open++; burst_in_frame = 0;
    end
    if (read) begin
      len = (req_left < int'(BURST)) ? req_left : int'(BURST);
      chk("address", address, req_addr);
      chk("burstcount", 32'(burstcount), 32'(len));
      chk("credit", 32'(FDEPTH - fifo_m - outst_m >= len), 32'd1);
    end
    // ---- drive inputs for the coming edge ----
    st_ready = force_ready0 ? 1'b0 : ($urandom_range(99) < rdy_pct);
    if (newreq && stall_armed && burst_in_frame == 1) begin
      stall_left = 10; stall_armed = 0;
    end
    if (read && stall_left > 0) begin
      waitrequest = 1'b1; stall_left--; stall_used++;
    end else waitrequest = ($urandom_range(99) < wr_pct);
    rdv_now = 0;
    if (rq_addr.size() > 0 && cyc >= rq_time[0] && $urandom_range(99) < rdv_pct) begin
      rdv_now = 1;
      readdata = pix(rq_addr.pop_front());
      void'(rq_time.pop_front());
    end else readdata = $urandom;
    readdatavalid = rdv_now;
    // ---- advance model over the coming edge ----
    acc = read && !waitrequest;
    pop_now = st_valid && st_ready;
`ifdef VFB_UNDERFLOW_CNT_EN
    if (in_frame_m && st_ready && fifo_m == 0) uf_m = uf_m + 32'd1;
`endif
    if (acc) begin
      for (int k = 0; k < len; k++) begin
        rq_addr.push_back(req_addr + 32'(4 * k));
        rq_time.push_back(cyc + lat);
      end
      acc_addr.push_back(req_addr); acc_len.push_back(len);
      outst_m += len; req_left -= len; req_addr += 32'(4 * len); burst_in_frame++;
      if (req_left == 0) req_active = 0;
      else if (rand_base && $urandom_range(3) == 0) base_addr = $urandom;
    end
    if (rdv_now) begin fifo_m++; outst_m--; end
    if (pop_now) begin
      fifo_m--;
      pop_data.push_back(st_data);
      if (pidx == N - 1) begin
        pidx = 0;
        if (base_q.size() > 0) void'(base_q.pop_front());
        frames_open--; eop_cnt++; in_frame_m = 0; start_ok = enable;
      end else begin
        pidx++; in_frame_m = 1;
      end
    end
    prev_read = read; prev_wait = waitrequest; prev_addr = address; prev_bc = burstcount;
    cyc++;
    if (frames_open == 0 && enable) start_ok = 1;
  endtask

  task automatic do_reset(input logic [31:0] new_base);
    sys_rst = 1'b1; readdatavalid = 1'b0; waitrequest = 1'b0; st_ready = 1'b0;
    #1;
    chk("rst_read", 32'(read), 32'd0);
    chk("rst_address", address, 32'd0);
    chk("rst_burstcount", 32'(burstcount), 32'd0);
    chk("rst_st_valid", 32'(st_valid), 32'd0);
    chk("rst_st_sop", 32'(st_sop), 32'd0);
    chk("rst_st_eop", 32'(st_eop), 32'd0);
    chk("rst_underflow_cnt", underflow_cnt, 32'd0);
    fifo_m = 0; outst_m = 0; req_active = 0; req_left = 0; pidx = 0; frames_open = 0;
    start_ok = 0; in_frame_m = 0; prev_read = 0; prev_wait = 0; uf_m = '0; stall_left = 0;
    base_q.delete(); rq_addr.delete(); rq_time.delete();
    base_addr = new_base;
    repeat (2) @(negedge clk);
    sys_rst = 1'b0;
  endtask

  initial begin
    int a0, p0, e0, s0;
    sys_rst = 0; enable = 0; base_addr = '0; waitrequest = 0; readdata = '0;
    readdatavalid = 0; st_ready = 0;
    lat = 1; wr_pct = 0; rdy_pct = 100; rdv_pct = 100; stall_left = 0; stall_used = 0;
    force_ready0 = 0; stall_armed = 0; rand_base = 0;
    cyc = 0; eop_cnt = 0; uf_m = '0;
    @(negedge clk);
    do_reset(32'h1000);

    // Basic frames, ideal memory and sink; base changes mid-frame 1
    enable = 1;
    a0 = acc_addr.size(); p0 = pop_data.size(); e0 = eop_cnt;
    for (int i = 0; i < 400 && eop_cnt < e0 + 2; i++) begin
      cycle();
      if (acc_addr.size() == a0 + 1) base_addr = 32'h2000;
    end
    chk("A_frames", 32'(eop_cnt - e0), 32'd2);
    chk("A_burst_count_ok", 32'(acc_addr.size() >= a0 + 6), 32'd1);
    if (acc_addr.size() >= a0 + 6)
      for (int i = 0; i < 6; i++) begin
        chk("A_burst_addr", acc_addr[a0 + i], exp_a[i]);
        chk("A_burst_len", 32'(acc_len[a0 + i]), 32'(exp_l[i]));
      end
    chk("A_pop_count_ok", 32'(pop_data.size() >= p0 + 11), 32'd1);
    if (pop_data.size() >= p0 + 11) begin
      chk("A_first_pixel", pop_data[p0], 32'hDEAD1000);
      chk("A_eop_pixel", pop_data[p0 + 9], 32'hDEAD1024);
      chk("A_next_sop_pixel", pop_data[p0 + 10], 32'hDEAD2000);
    end

    // Ten-cycle waitrequest stall on a second burst, bursty sink
    stall_armed = 1; rdy_pct = 70; lat = 3; e0 = eop_cnt; s0 = stall_used;
    for (int i = 0; i < 800 && eop_cnt < e0 + 2; i++) cycle();
    chk("B_frames", 32'(eop_cnt - e0), 32'd2);
    chk("B_stall_cycles", 32'(stall_used - s0), 32'd10);

    // Sink never ready: credits cap requests at FIFO_DEPTH words
    do_reset(32'h3000);
    force_ready0 = 1; lat = 2; a0 = acc_addr.size();
    for (int i = 0; i < 80; i++) cycle();
    chk("C_bursts", 32'(acc_addr.size() - a0), 32'(FDEPTH / int'(BURST)));
    chk("C_read_idle", 32'(read), 32'd0);
    chk("C_st_valid", 32'(st_valid), 32'd1);
    chk("C_st_data_frozen", st_data, 32'hDEAD3000);
    force_ready0 = 0; rdy_pct = 100; e0 = eop_cnt;
    for (int i = 0; i < 300 && eop_cnt < e0 + 1; i++) cycle();
    chk("C_frames", 32'(eop_cnt - e0), 32'd1);

    // Reset while a request is pending, then restart from the new base
    wr_pct = 20; lat = 1;
    for (int i = 0; i < 50 && read !== 1'b1; i++) cycle();
    chk("D_read_seen", 32'(read), 32'd1);
    do_reset(32'h4000);
    a0 = acc_addr.size(); p0 = pop_data.size(); e0 = eop_cnt;
    for (int i = 0; i < 300 && eop_cnt < e0 + 1; i++) cycle();
    chk("D_frames", 32'(eop_cnt - e0), 32'd1);
    if (acc_addr.size() > a0) chk("D_restart_addr", acc_addr[a0], 32'h4000);
    if (pop_data.size() > p0) chk("D_restart_pixel", pop_data[p0], 32'hDEAD4000);

    // Random traffic with random base changes, then enable drop mid-frame
    rdy_pct = 60; wr_pct = 30; rdv_pct = 70; lat = 4; rand_base = 1;
    for (int i = 0; i < 800; i++) cycle();
    for (int i = 0; i < 200 && !req_active; i++) cycle();
    chk("E_mid_frame", 32'(req_active), 32'd1);
    enable = 0; e0 = eop_cnt;
    for (int i = 0; i < 600 && frames_open != 0; i++) cycle();
    chk("E_frame_completed", 32'(eop_cnt - e0), 32'd1);
    a0 = acc_addr.size();
    for (int i = 0; i < 40; i++) cycle();
    chk("E_no_new_frame", 32'(acc_addr.size() - a0), 32'd0);
    chk("E_read_idle", 32'(read), 32'd0);
    rand_base = 0;

    // Long memory latency with an always-ready sink: starvation counting
    enable = 1; lat = 20; rdy_pct = 100; wr_pct = 0; rdv_pct = 100; e0 = eop_cnt;
    for (int i = 0; i < 1000 && eop_cnt < e0 + 1; i++) cycle();
    chk("F_frames", 32'(eop_cnt - e0), 32'd1);
`ifdef VFB_UNDERFLOW_CNT_EN
    chk("F_underflow_cnt", underflow_cnt, uf_m);
`else
    chk("F_underflow_off", underflow_cnt, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
